timeout_counter: RTL and testbench

- Parametrised up/down terminal-count counter; generalised successor of the game's single-purpose cycle counter.
- Used for Lemmings fall-duration timeout (splat detection), dig/walk step timers and frame-rate dividers.
- Adds runtime terminal value, direction, wrap/saturate/one-shot modes, parallel load, sticky done and one-cycle terminal pulse.

---
 rtl/counter_pkg.sv | 14 +
 rtl/timeout_counter.sv | 89 ++++++++
 tb/tb_timeout_counter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared counter types and default constants for the timeout counter and
// the lemming FSM that uses it.
package counter_pkg;

  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2
  } mode_e;

  localparam int unsigned COUNT_W_DEF  = 8;
  localparam int unsigned FALL_TIMEOUT = 20;

endpackage

// File: rtl/timeout_counter.sv
// Up/down terminal-count counter with wrap/saturate/one-shot modes, parallel
// load, sticky done flag and a one-cycle arrival pulse.
module timeout_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH        = COUNT_W_DEF,
  parameter int unsigned TERMINAL_DEF = FALL_TIMEOUT
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             use_def,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             signal,
  output logic             done,
  output logic             busy
);

  localparam logic [WIDTH-1:0] TermDef = WIDTH'(TERMINAL_DEF);

  logic [WIDTH-1:0] count_q, count_d;
  logic             signal_q, signal_d;
  logic             done_q, done_d;
  logic             halted_q, halted_d;

  logic [WIDTH-1:0] term, target, restart, stepped;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);
  assign term     = use_def ? TermDef : term_val;
  assign target   = dir ? '0 : term;
  assign restart  = dir ? term : '0;
  assign stepped  = dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));

  always_comb begin
    count_d  = count_q;
    signal_d = 1'b0;
    done_d   = done_q;
    halted_d = halted_q;
    if (reset) begin
      count_d  = '0;
      done_d   = 1'b0;
      halted_d = 1'b0;
    end else if (load) begin
      count_d  = load_val;
      done_d   = 1'b0;
      halted_d = 1'b0;
    end else if (en && !halted_q) begin
      if (count_q != target) begin
        // Plain modular step; a count past the target walks around to it.
        count_d = stepped;
        if (stepped == target) begin
          signal_d = 1'b1;
          done_d   = 1'b1;
          if (mode_sel == ONESHOT) halted_d = 1'b1;
        end
      end else if (mode_sel == WRAP) begin
        count_d = restart;
      end
      // SAT and the unused encoding hold at the target.
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      count_q  <= '0;
      signal_q <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      signal_q <= signal_d;
      done_q   <= done_d;
      halted_q <= halted_d;
    end
  end

  assign count  = count_q;
  assign signal = signal_q;
  assign done   = done_q;
  assign busy   = ~halted_q;

endmodule

// File: tb/tb_timeout_counter.sv
// Directed bench for timeout_counter: expected outputs are queued as each
// step is driven and compared after the following clock edge.
module tb_timeout_counter;
  import counter_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         areset_n, reset, en, load, dir, use_def;
  logic [W-1:0] load_val, term_val, count;
  logic [1:0]   mode;
  logic         signal, done, busy;

  typedef struct {
    string        tag;
    logic [W-1:0] count;
    logic         signal;
    logic         done;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  timeout_counter #(.WIDTH(W), .TERMINAL_DEF(20)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .mode     (mode),
    .use_def  (use_def),
    .term_val (term_val),
    .count    (count),
    .signal   (signal),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, want);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard: observed empty queue expected entry");
      return;
    end
    e = exp_q.pop_front();
    chk({e.tag, ".count"}, 32'(count), 32'(e.count));
    chk({e.tag, ".signal"}, 32'(signal), 32'(e.signal));
    chk({e.tag, ".done"}, 32'(done), 32'(e.done));
    chk({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
  endtask

  // Inputs are already set; queue expectation, clock once, compare.
  task automatic step(input string tag, input int c, input logic s, input logic d,
                      input logic b);
    exp_t e;
    e.tag = tag; e.count = W'(c); e.signal = s; e.done = d; e.busy = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    areset_n = 1'b0; reset = 1'b0; en = 1'b0; load = 1'b0; load_val = '0;
    dir = 1'b0; mode = WRAP; use_def = 1'b1; term_val = '0;
    #12 areset_n = 1'b1;
    step("por", 0, 0, 0, 1);

    // Count to 7 then pull async reset between edges.
    en = 1'b1;
    for (int i = 1; i <= 7; i++) step("pre_rst", i, 0, 0, 1);
    #2 areset_n = 1'b0;
    #1;
    exp_q.push_back('{tag: "async_rst", count: 0, signal: 0, done: 0, busy: 1});
    pop_check();
    en = 1'b0;
    #2 areset_n = 1'b1;
    step("post_rst", 0, 0, 0, 1);

    // Up WRAP on default terminal 20.
    en = 1'b1;
    for (int i = 1; i <= 45; i++)
      step("wrap", i % 21, (i == 20 || i == 41), (i >= 20), 1);

    // Down ONESHOT from 5.
    en = 1'b0; mode = ONESHOT; dir = 1'b1; load = 1'b1; load_val = 8'd5;
    step("os_load", 5, 0, 0, 1);
    load = 1'b0; en = 1'b1;
    for (int i = 4; i >= 1; i--) step("os_cnt", i, 0, 0, 1);
    step("os_arrive", 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) step("os_halt", 0, 0, 1, 0);
    load = 1'b1; load_val = 8'd3;
    step("os_reload", 3, 0, 0, 1);
    load = 1'b0;

    // SAT up with runtime terminal, then raise the terminal.
    mode = SAT; dir = 1'b0; use_def = 1'b0; term_val = 8'd3; reset = 1'b1;
    step("sat_clr", 0, 0, 0, 1);
    reset = 1'b0;
    step("sat", 1, 0, 0, 1);
    step("sat", 2, 0, 0, 1);
    step("sat_arrive", 3, 1, 1, 1);
    step("sat_hold", 3, 0, 1, 1);
    step("sat_hold", 3, 0, 1, 1);
    term_val = 8'd6;
    step("sat2", 4, 0, 1, 1);
    step("sat2", 5, 0, 1, 1);
    step("sat2_arrive", 6, 1, 1, 1);
    step("sat2_hold", 6, 0, 1, 1);

    // Priority: reset over load over en; load onto target does not pulse.
    reset = 1'b1; load = 1'b1; load_val = 8'd20;
    step("prio_rst", 0, 0, 0, 1);
    reset = 1'b0; use_def = 1'b1; mode = WRAP;
    step("prio_load", 20, 0, 0, 1);
    load = 1'b0;

    // Enable gating just below the terminal.
    en = 1'b0; load = 1'b1; load_val = 8'd19;
    step("gate_load", 19, 0, 0, 1);
    load = 1'b0;
    for (int i = 0; i < 5; i++) step("gate_hold", 19, 0, 0, 1);
    en = 1'b1;
    step("gate_arrive", 20, 1, 1, 1);

    // Degenerate T=0 up: holds at 0, and a loaded value walks around to 0.
    use_def = 1'b0; term_val = '0; reset = 1'b1;
    step("t0_clr", 0, 0, 0, 1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("t0_hold", 0, 0, 0, 1);
    load = 1'b1; load_val = 8'd254;
    step("t0_load", 254, 0, 0, 1);
    load = 1'b0;
    step("t0_step", 255, 0, 0, 1);
    step("t0_arrive", 0, 1, 1, 1);
    step("t0_wrap", 0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
